// File: rtl/regfile_writeback_queue.sv
// Write-back queue in front of the register file's single write port.
// Buffers ALU and load results in order and retires one register write per cycle.
module regfile_writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [ADDR_W-1:0]        alu_rd,
  input  logic [DATA_W-1:0]        alu_data,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [ADDR_W-1:0]        ld_rd,
  input  logic [DATA_W-1:0]        ld_data,
  output logic [ADDR_W-1:0]        R3_addr,
  output logic [DATA_W-1:0]        R3_data,
  output logic                     R3_wr_en,
  output logic [31:0]              pending_mask,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic [DEPTH-1:0]  r_valid;
  logic [ADDR_W-1:0] r_rd   [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];

  logic              r_wr_en;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic              w_alu_push;
  logic              w_ld_push;
  logic              w_deq;
  logic [PTR_W-1:0]  w_ld_slot;
  logic [PTR_W-1:0]  w_tail_next;
  logic [CNT_W-1:0]  w_count_next;
  logic [31:0]       w_mask;

  // Readiness looks only at registered occupancy, so both producers can fire together.
  assign alu_ready = (r_count <= CNT_W'(DEPTH - 1));
  assign ld_ready  = (r_count <= CNT_W'(DEPTH - 2));

  // Writes to x0 finish the handshake but are never stored.
  assign w_alu_push = alu_valid && alu_ready && (alu_rd != '0);
  assign w_ld_push  = ld_valid  && ld_ready  && (ld_rd  != '0);
  assign w_deq      = (r_count != '0);

  assign w_ld_slot    = w_alu_push ? r_tail + PTR_W'(1) : r_tail;
  assign w_tail_next  = r_tail + PTR_W'(w_alu_push) + PTR_W'(w_ld_push);
  assign w_count_next = r_count + CNT_W'(w_alu_push) + CNT_W'(w_ld_push) - CNT_W'(w_deq);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
      r_wr_en <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      // NOTE: non-blocking assignments let the clear of the head slot and the
      // sets of the tail slots below all see the same pre-edge state.
      r_tail  <= w_tail_next;
      r_count <= w_count_next;
      r_wr_en <= w_deq;
      if (w_deq) begin
        r_addr           <= r_rd[r_head];
        r_wdata          <= r_data[r_head];
        r_head           <= r_head + PTR_W'(1);
        r_valid[r_head]  <= 1'b0;
      end
      if (w_alu_push) r_valid[r_tail]    <= 1'b1;
      if (w_ld_push)  r_valid[w_ld_slot] <= 1'b1;
    end
  end

  // NOTE: the entry storage carries no reset; r_valid alone decides whether a
  // slot is meaningful, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (w_alu_push) begin
      r_rd[r_tail]   <= alu_rd;
      r_data[r_tail] <= alu_data;
    end
    if (w_ld_push) begin
      r_rd[w_ld_slot]   <= ld_rd;
      r_data[w_ld_slot] <= ld_data;
    end
  end

  always_comb begin
    // NOTE: assigning the default first keeps this block free of inferred latches.
    w_mask = '0;
    for (int r = 1; r < 32; r++) begin
      if (r_wr_en && (r_addr == ADDR_W'(r))) w_mask[r] = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        if (r_valid[i] && (r_rd[i] == ADDR_W'(r))) w_mask[r] = 1'b1;
      end
    end
  end

  assign pending_mask = w_mask;
  assign count        = r_count;
  assign R3_wr_en     = r_wr_en;
  assign R3_addr      = r_addr;
  assign R3_data      = r_wdata;

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Randomised and directed bench for regfile_writeback_queue against an in-order queue model.
module tb_regfile_writeback_queue;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              alu_valid, alu_ready, ld_valid, ld_ready;
  logic [ADDR_W-1:0] alu_rd, ld_rd, R3_addr;
  logic [DATA_W-1:0] alu_data, ld_data, R3_data;
  logic              R3_wr_en;
  logic [31:0]       pending_mask;
  logic [CNT_W-1:0]  count;

  regfile_writeback_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .R3_addr(R3_addr), .R3_data(R3_data), .R3_wr_en(R3_wr_en),
    .pending_mask(pending_mask), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t               q[$];
  logic              m_wr;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  int                n_checks = 0;
  int                n_errors = 0;
  logic [DATA_W-1:0] tb_rf [32];

  always @(posedge clk) if (R3_wr_en) tb_rf[R3_addr] <= R3_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    foreach (q[i]) m[q[i].rd] = 1'b1;
    if (m_wr) m[m_addr] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  task automatic model_reset();
    q.delete();
    m_wr   = 1'b0;
    m_addr = '0;
    m_data = '0;
  endtask

  task automatic compare_all();
    check("alu_ready", 64'(alu_ready), 64'(q.size() <= DEPTH - 1));
    check("ld_ready",  64'(ld_ready),  64'(q.size() <= DEPTH - 2));
    check("count",     64'(count),     64'(q.size()));
    check("R3_wr_en",  64'(R3_wr_en),  64'(m_wr));
    check("R3_addr",   64'(R3_addr),   64'(m_addr));
    check("R3_data",   64'(R3_data),   64'(m_data));
    check("pending_mask", 64'(pending_mask), 64'(model_mask()));
  endtask

  // One clock: drive at the falling edge, update the model at the rising edge, compare at the next falling edge.
  task automatic step(input logic av, input logic [ADDR_W-1:0] ard, input logic [DATA_W-1:0] ad,
                      input logic lv, input logic [ADDR_W-1:0] lrd, input logic [DATA_W-1:0] ldd,
                      output logic a_acc, output logic l_acc);
    alu_valid = av;  alu_rd = ard;  alu_data = ad;
    ld_valid  = lv;  ld_rd  = lrd;  ld_data  = ldd;
    a_acc = av && (q.size() <= DEPTH - 1);
    l_acc = lv && (q.size() <= DEPTH - 2);
    @(posedge clk);
    if (q.size() > 0) begin
      m_wr   = 1'b1;
      m_addr = q[0].rd;
      m_data = q[0].data;
      void'(q.pop_front());
    end else begin
      m_wr = 1'b0;
    end
    if (a_acc && ard != '0) q.push_back('{rd: ard, data: ad});
    if (l_acc && lrd != '0) q.push_back('{rd: lrd, data: ldd});
    @(negedge clk);
    compare_all();
  endtask

  task automatic push(input logic av, input logic [ADDR_W-1:0] ard, input logic [DATA_W-1:0] ad,
                      input logic lv, input logic [ADDR_W-1:0] lrd, input logic [DATA_W-1:0] ldd);
    logic a_acc, l_acc;
    step(av, ard, ad, lv, lrd, ldd, a_acc, l_acc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) push(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    logic              a_v, l_v, a_acc, l_acc;
    logic [ADDR_W-1:0] a_rd, l_rd;
    logic [DATA_W-1:0] a_d, l_d;
    int                ai, li;

    reset = 1'b1;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid  = 1'b0; ld_rd  = '0; ld_data  = '0;
    for (int r = 0; r < 32; r++) tb_rf[r] = '0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    check("reset_count", 64'(count), 64'd0);
    reset = 1'b0;

    // Single write: visible on the port one cycle after acceptance.
    push(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
    check("single_mask_N", 64'(pending_mask), 64'h20);
    check("single_wr_N", 64'(R3_wr_en), 64'd0);
    idle(1);
    check("single_wr_N1", 64'(R3_wr_en), 64'd1);
    check("single_addr_N1", 64'(R3_addr), 64'd5);
    check("single_data_N1", 64'(R3_data), 64'hDEADBEEF);
    check("single_mask_N1", 64'(pending_mask), 64'h20);
    idle(1);
    check("single_wr_N2", 64'(R3_wr_en), 64'd0);
    check("single_mask_N2", 64'(pending_mask), 64'd0);
    check("single_rf5", 64'(tb_rf[5]), 64'hDEADBEEF);

    // Dual push to the same register: ALU entry is older, load value wins.
    push(1'b1, 5'd1, 32'h11, 1'b1, 5'd1, 32'h22);
    idle(1);
    check("dual_first_addr", 64'(R3_addr), 64'd1);
    check("dual_first_data", 64'(R3_data), 64'h11);
    idle(1);
    check("dual_second_wr", 64'(R3_wr_en), 64'd1);
    check("dual_second_data", 64'(R3_data), 64'h22);
    idle(2);
    check("dual_rf1", 64'(tb_rf[1]), 64'h22);

    // Backpressure: both producers always valid, items held until accepted.
    ai = 0; li = 0;
    for (int c = 0; c < 16; c++) begin
      step(ai < 4, 5'(2 + ai), 32'hA000 + 32'(ai), li < 4, 5'(6 + li), 32'hB000 + 32'(li), a_acc, l_acc);
      if (a_acc) ai++;
      if (l_acc) li++;
    end
    idle(6);
    check("bp_rf5", 64'(tb_rf[5]), 64'hA003);
    check("bp_rf9", 64'(tb_rf[9]), 64'hB003);

    // x0 write is accepted and dropped.
    check("x0_ld_ready", 64'(ld_ready), 64'd1);
    push(1'b0, '0, '0, 1'b1, 5'd0, 32'h1234);
    check("x0_count", 64'(count), 64'd0);
    check("x0_mask0", 64'(pending_mask[0]), 64'd0);
    idle(1);
    check("x0_wr", 64'(R3_wr_en), 64'd0);

    // Reset asserted between edges while draining.
    push(1'b1, 5'd10, 32'h10, 1'b1, 5'd11, 32'h11);
    push(1'b1, 5'd12, 32'h12, 1'b1, 5'd13, 32'h13);
    check("pre_reset_count", 64'(count), 64'd3);
    alu_valid = 1'b0; ld_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async_reset_wr", 64'(R3_wr_en), 64'd0);
    check("async_reset_count", 64'(count), 64'd0);
    check("async_reset_mask", 64'(pending_mask), 64'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    compare_all();
    idle(4);

    // Wrap-around streaming: one write per cycle keeps occupancy at one.
    for (int k = 1; k <= 10; k++) begin
      push(1'b1, 5'(k), 32'(k * 256), 1'b0, '0, '0);
      if (k >= 2) begin
        check("wrap_count", 64'(count), 64'd1);
        check("wrap_addr", 64'(R3_addr), 64'(k - 1));
        check("wrap_data", 64'(R3_data), 64'((k - 1) * 256));
      end
    end
    idle(3);

    // Random traffic with producers holding data while not accepted.
    a_v = 1'b0; l_v = 1'b0; a_rd = '0; l_rd = '0; a_d = '0; l_d = '0;
    for (int c = 0; c < 400; c++) begin
      step(a_v, a_rd, a_d, l_v, l_rd, l_d, a_acc, l_acc);
      if (!(a_v && !a_acc)) begin
        a_v  = ($urandom_range(0, 3) != 0);
        a_rd = 5'($urandom_range(0, 7));
        a_d  = $urandom;
      end
      if (!(l_v && !l_acc)) begin
        l_v  = ($urandom_range(0, 2) != 0);
        l_rd = 5'($urandom_range(0, 7));
        l_d  = $urandom;
      end
      if (c == 200) begin
        check("rand_count_bound", 64'(count <= CNT_W'(DEPTH)), 64'd1);
      end
    end
    idle(6);
    check("final_count", 64'(count), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
